// File: rtl/cpu_mem_responder_if.sv
// CPU and program-loader bus bundle for cpu_mem_responder.
// master = data_path / loader side, slave = memory responder side.
// All signals are plain levels sampled on the responder clock.
interface cpu_mem_responder_if #(
    parameter int ADDR_W = 8
);
    // instruction fetch
    logic [31:0]       pc;
    logic [31:0]       instr;
    // data access
    logic [31:0]       addr_data;
    logic [31:0]       write_data;
    logic              we;
    logic [31:0]       read_data;
    // program loader
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic              prog_start;
    // status
    logic              ready;
    logic [15:0]       prog_count;
    logic              fault;
    logic [31:0]       fault_addr;

    modport master (
        output pc, addr_data, write_data, we,
        output prog_we, prog_addr, prog_data, prog_start,
        input  instr, read_data, ready, prog_count, fault, fault_addr
    );

    modport slave (
        input  pc, addr_data, write_data, we,
        input  prog_we, prog_addr, prog_data, prog_start,
        output instr, read_data, ready, prog_count, fault, fault_addr
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Instruction/data RAM responder for data_path, with LOAD/RUN gating and sticky fault capture.
// Latency: instr and read_data are registered, one clock after pc/addr_data are sampled.
// Backpressure: none; every cycle is accepted, illegal accesses are absorbed and flagged.
module cpu_mem_responder #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    cpu_mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Word-organised memories; deliberately not reset so loaded contents survive reset.
    logic [31:0] imem [DEPTH];
    logic [31:0] dmem [DEPTH];

    logic [ADDR_W-1:0] pc_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              pc_bad;
    logic              data_bad;
    logic              in_run;
    logic              prog_wr;
    logic              data_wr;

    logic [31:0] instr_q;
    logic [31:0] read_data_q;
    logic [15:0] prog_count_q;
    logic        fault_q;
    logic [31:0] fault_addr_q;

    // Byte address -> word index; anything misaligned or past the array depth is illegal.
    assign pc_idx   = bus.pc[ADDR_W+1:2];
    assign data_idx = bus.addr_data[ADDR_W+1:2];
    assign pc_bad   = (bus.pc[1:0] != 2'b00) || (|bus.pc[31:ADDR_W+2]);
    assign data_bad = (bus.addr_data[1:0] != 2'b00) || (|bus.addr_data[31:ADDR_W+2]);

    // Loader writes only while idle; CPU stores only while running and legal.
    assign prog_wr = (state == S_LOAD) && bus.prog_we;
    assign data_wr = in_run && bus.we && !data_bad;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: LOAD leaves on prog_start; RUN is left only through reset.
    always_comb begin
        state_nxt = state;
        in_run    = 1'b0;
        case (state)
            S_LOAD: begin
                if (bus.prog_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                in_run = 1'b1;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    // RAM writes; a write pending at an edge where reset is high is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (!reset) begin
            if (prog_wr) begin
                imem[bus.prog_addr] <= bus.prog_data;
            end
            if (data_wr) begin
                dmem[data_idx] <= bus.write_data;
            end
        end
    end

    // Registered fetch/load results, loader counter and first-fault capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q      <= NOP_WORD;
            read_data_q  <= 32'h0;
            prog_count_q <= 16'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else if (in_run) begin
            instr_q <= pc_bad ? NOP_WORD : imem[pc_idx];
            // Write-first: a same-cycle store is forwarded instead of the old word.
            if (data_bad) begin
                read_data_q <= 32'h0;
            end else if (bus.we) begin
                read_data_q <= bus.write_data;
            end else begin
                read_data_q <= dmem[data_idx];
            end
            // addr_data is always driven, so it is checked even when we is low.
            if (pc_bad || data_bad) begin
                fault_q <= 1'b1;
                if (!fault_q) begin
                    fault_addr_q <= pc_bad ? bus.pc : bus.addr_data;
                end
            end
        end else begin
            instr_q     <= NOP_WORD;
            read_data_q <= 32'h0;
            if (prog_wr && (prog_count_q != 16'hFFFF)) begin
                prog_count_q <= prog_count_q + 16'd1;
            end
        end
    end

    assign bus.instr      = instr_q;
    assign bus.read_data  = read_data_q;
    assign bus.ready      = in_run;
    assign bus.prog_count = prog_count_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for data_path: serves instruction fetch on pc -> instr and data access on addr_data/write_data/we -> read_data.
- Contains a word-organised instruction RAM, loaded over a program port while the CPU is held idle, and a data RAM.
- A LOAD/RUN state machine gates CPU access.
- Sticky fault capture flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 8, word-index bits per memory; depth = 2**ADDR_W words of 32 bits each.
- NOP_WORD, 32'h0000_0000, value driven on instr when no valid fetch is available.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc  input  32  byte address of the instruction fetch, from data_path.
- instr  output  32  fetched instruction, registered.
- addr_data  input  32  byte address of the data access, from data_path.
- write_data  input  32  store data, from data_path.
- we  input  1  data write enable, from data_path.
- read_data  output  32  load data, registered.
- prog_we  input  1  instruction RAM write strobe, honoured in LOAD only.
- prog_addr  input  ADDR_W  instruction RAM word index.
- prog_data  input  32  instruction word to write.
- prog_start  input  1  one-cycle pulse: LOAD -> RUN.
- ready  output  1  high in RUN.
- prog_count  output  16  instruction words written since reset; saturates at 16'hFFFF.
- fault  output  1  sticky; set by the first illegal CPU access.
- fault_addr  output  32  byte address of the first illegal access.

Behaviour:
- Reset (async, active-high), outputs forced immediately:
  - instr=NOP_WORD, read_data=0, ready=0, prog_count=0, fault=0, fault_addr=0, state=LOAD.
  - RAM contents are not cleared and survive reset. A read of a never-written word returns X; the bench must not check it.
- Address decode, applied to each of pc and addr_data independently:
  - index = a[ADDR_W+1:2].
  - Illegal if a[1:0]!=0, or if a[31:ADDR_W+2]!=0.
- State LOAD:
  - prog_we=1 writes imem[prog_addr]=prog_data at the clk edge; prog_count increments (saturating).
  - instr=NOP_WORD, read_data=0.
  - CPU we ignored: no dmem write, no fault evaluation.
  - prog_start=1 -> RUN at the next edge. If prog_we and prog_start are high in the same cycle, the write completes, then the state enters RUN.
- State RUN:
  - ready=1; prog_we and prog_start ignored. Only reset returns the block to LOAD.
  - Fetch latency 1: instr at edge N+1 = imem[index(pc at edge N)]. An illegal pc yields instr=NOP_WORD.
  - Data store: we=1 with a legal addr_data writes dmem[index]=write_data at the edge. An illegal address suppresses the write.
  - Data load latency 1: read_data at edge N+1 = dmem[index(addr_data at edge N)], write-first. If a write to the same index occurs in the same cycle, read_data=write_data.
  - An illegal addr_data yields read_data=0.
- Fault:
  - Any illegal pc or addr_data seen in RUN at an edge sets fault=1.
  - If fault was 0, fault_addr captures the address. pc has priority when both are illegal in the same cycle.
  - Later faults do not overwrite fault_addr.
  - The illegal-access check on addr_data applies on every RUN cycle regardless of we, because data_path drives addr_data continuously.
- Reset mid-operation:
  - An edge-pending write is dropped.
  - State returns to LOAD and outputs go to their reset values.
  - Previously loaded imem/dmem contents remain valid after the next prog_start.
- The two RAMs are separate: imem is not writable from the CPU port, and dmem is not writable from the program port.

Test Plan:
- Load and fetch: reset; prog_we writes word 0 = 32'h03A0_3002 and word 1 = 32'h0283_3001; pulse prog_start; pc=0, then pc=4.
  - Required: prog_count=2, ready=1 one edge after prog_start, instr=32'h03A0_3002 one edge after pc=0, then 32'h0283_3001.
- Store/load: in RUN, we=1, addr_data=32'h10, write_data=32'hDEAD_BEEF; next cycle we=0, same address.
  - Required: read_data=32'hDEAD_BEEF, available the same edge as the write (write-first), and held on the next read.
- Illegal access: addr_data=32'h0000_0402 with we=1, ADDR_W=8 (misaligned).
  - Required: no dmem change, read_data=0, fault=1, fault_addr=32'h0000_0402.
  - A subsequent pc=32'h0000_0400 sets neither fault_addr nor anything else: fault_addr is unchanged.
- LOAD isolation: before prog_start, drive we=1, addr_data=0, write_data=5, and pc=0.
  - Required: instr=0, read_data=0, fault=0; reading dmem[0] after RUN shows the earlier value, not 5.
- Reset mid-run: assert reset asynchronously between edges while in RUN.
  - Required: instr=0, ready=0, fault=0 immediately.
  - After release and prog_start with no reload, pc=4 returns the previously loaded 32'h0283_3001.
